// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//
// Show-ahead FIFO that buffers ALU results together with their flags and
// opcode. Results whose opcode is illegal (3'b110 / 3'b111) are handshaken
// but dropped, and a saturating error counter records each drop. A sticky
// flag remembers that a stored result carried out since it was last cleared.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous active-high reset
//   in_valid      : producer presents a result
//   in_ready      : block accepts the presented result this cycle
//   in_result     : 4-bit ALU result
//   in_carry      : ALU carry out
//   in_zero       : ALU zero flag
//   in_op         : opcode that produced the result
//   out_valid     : head entry available
//   out_ready     : consumer takes the head entry
//   out_data      : head entry {op[2:0], carry, zero, result[3:0]}, 0 if empty
//   count         : number of stored entries
//   clear_sticky  : clears sticky_carry (a same-edge carry push wins)
//   sticky_carry  : a stored entry with carry=1 was accepted since last clear
//   err_cnt       : dropped illegal-op results, saturating at 15
// ---------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_result,
  input  logic                     in_carry,
  input  logic                     in_zero,
  input  logic [2:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8:0]               out_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clear_sticky,
  output logic                     sticky_carry,
  output logic [3:0]               err_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [2:0]    OP_MAX  = 3'b101;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          sticky_q, sticky_d;
  logic [3:0]    err_q, err_d;

  logic accept;
  logic legal;
  logic push;
  logic illegal;
  logic pop;

  // Readiness ignores out_ready on purpose: a full block never takes a new
  // entry even if the head leaves on the same edge. Both handshake outputs
  // are forced low during reset.
  always_comb begin
    in_ready  = !rst && (count_q != DEPTH_C);
    out_valid = !rst && (count_q != '0);
    out_data  = out_valid ? mem_q[rptr_q] : 9'h000;

    accept  = in_valid && in_ready;
    legal   = (in_op <= OP_MAX);
    push    = accept && legal;
    illegal = accept && !legal;
    pop     = out_valid && out_ready;
  end

  // Next-state logic. Pointers are AW bits wide, so the power-of-two depth
  // makes the increment wrap modulo DEPTH for free.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    err_d    = err_q;

    if (push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    // The set is evaluated last so a carry push beats a same-edge clear.
    if (clear_sticky) begin
      sticky_d = 1'b0;
    end
    if (push && in_carry) begin
      sticky_d = 1'b1;
    end

    if (illegal && (err_q != 4'hF)) begin
      err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      err_q    <= 4'h0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {in_op, in_carry, in_zero, in_result};
    end
  end

  assign count        = count_q;
  assign sticky_carry = sticky_q;
  assign err_cnt      = err_q;

endmodule
